arcade_input_merge: RTL and testbench

Parametrised player-input front end for arcade cores, placed between `hps_io` and the game core. It turns `ps2_key` toggle events into per-player button state through a run-time programmable scancode map, and ORs that state with the per-player joystick words. It also stretches coin requests into fixed-width pulses and, optionally, applies a 4-way joystick filter per player. It replaces hard-coded per-core keyboard `casex` decoders.

---
 rtl/arcade_input_merge_if.sv | 14 +
 rtl/arcade_input_merge.sv | 187 ++++++++++++++++++
 tb/tb_arcade_input_merge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_merge_if.sv
// rtl/arcade_input_merge_if.sv - keyboard event and keymap write bus for arcade_input_merge
interface arcade_input_merge_if #(
  parameter int MAP_DEPTH = 16
);
  localparam int AW = $clog2(MAP_DEPTH);

  logic [10:0]   ps2_key;
  logic          map_wr;
  logic [AW-1:0] map_addr;
  logic [17:0]   map_data;

  modport master (output ps2_key, map_wr, map_addr, map_data);
  modport slave  (input  ps2_key, map_wr, map_addr, map_data);
endinterface

// File: rtl/arcade_input_merge.sv
// rtl/arcade_input_merge.sv - ps2 keymap + joystick merge, coin stretcher, optional 4-way filter
module arcade_input_merge #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 8,
  parameter int MAP_DEPTH  = 16,
  parameter int COIN_PULSE = 1200000,
  parameter int FOURWAY    = 0
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  arcade_input_merge_if.slave        bus,
  input  logic [16*PLAYERS-1:0]      joystick,
  output logic [PLAYERS*BUTTONS-1:0] btn_out,
  output logic [PLAYERS-1:0]         coin,
  output logic                       busy,
  output logic                       overflow
);
  localparam int NB = PLAYERS * BUTTONS;
  localparam int AW = $clog2(MAP_DEPTH);
  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAP_DEPTH - 1);
  localparam logic [CW-1:0] PULSE    = CW'(COIN_PULSE);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

  state_t                        state;
  logic [AW-1:0]                 idx;
  logic                          tog_q;
  logic                          tog_primed;
  logic                          slot_full;
  logic [9:0]                    slot_evt;
  logic [9:0]                    cur_evt;
  logic [MAP_DEPTH-1:0]          map_valid;
  logic [MAP_DEPTH-1:0][8:0]     map_code;
  logic [MAP_DEPTH-1:0][7:0]     map_tgt;
  logic [NB-1:0]                 key_state;
  logic [PLAYERS-1:0]            key_coin;

  logic                          new_evt;
  logic                          slot_take;
  logic                          scan_hit;

  // tog_primed keeps the first post-reset load of the toggle bit from looking like an event
  assign new_evt   = tog_primed && (tog_q != bus.ps2_key[10]);
  assign slot_take = slot_full && (state == IDLE || state == APPLY);
  assign scan_hit  = (state == SCAN) && map_valid[idx] && (map_code[idx] == cur_evt[8:0]);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      tog_q      <= 1'b0;
      tog_primed <= 1'b0;
      slot_full  <= 1'b0;
      slot_evt   <= '0;
      cur_evt    <= '0;
      map_valid  <= '0;
      map_code   <= '0;
      map_tgt    <= '0;
      key_state  <= '0;
      key_coin   <= '0;
    end else begin
      tog_q      <= bus.ps2_key[10];
      tog_primed <= 1'b1;

      if (bus.map_wr && (int'(bus.map_addr) < MAP_DEPTH)) begin
        map_valid[bus.map_addr] <= bus.map_data[17];
        map_code[bus.map_addr]  <= bus.map_data[16:8];
        map_tgt[bus.map_addr]   <= bus.map_data[7:0];
      end

      // a slot emptied by the FSM this cycle can take a new event at the same edge
      if (new_evt) begin
        if (!slot_full || slot_take) begin
          slot_full <= 1'b1;
          slot_evt  <= bus.ps2_key[9:0];
        end else begin
          overflow <= 1'b1;
        end
      end else if (slot_take) begin
        slot_full <= 1'b0;
      end

      for (int t = 0; t < NB; t++)
        if (scan_hit && map_tgt[idx] == 8'(t)) key_state[t] <= cur_evt[9];
      for (int p = 0; p < PLAYERS; p++)
        if (scan_hit && map_tgt[idx] == 8'(NB + p)) key_coin[p] <= cur_evt[9];

      case (state)
        IDLE: begin
          if (slot_full) begin
            state   <= SCAN;
            cur_evt <= slot_evt;
            idx     <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) state <= APPLY;
          else                 idx   <= idx + AW'(1);
        end
        APPLY: begin
          if (slot_full) begin
            state   <= SCAN;
            cur_evt <= slot_evt;
            idx     <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [3:0] lowest(input logic [3:0] v);
    lowest = v & (~v + 4'd1);
  endfunction

  logic [NB-1:0]                pre;
  logic [NB-1:0]                filt;
  logic [PLAYERS-1:0]           req;
  logic [PLAYERS-1:0]           req_q;
  logic [PLAYERS-1:0][3:0]      pre_q;
  logic [PLAYERS-1:0][3:0]      last_dir;
  logic [PLAYERS-1:0][3:0]      dir_next;
  logic [PLAYERS-1:0][CW-1:0]   cnt;
  logic                         unused_joy;

  always_comb begin
    unused_joy = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int b = 0; b < BUTTONS; b++)
        pre[p*BUTTONS+b] = key_state[p*BUTTONS+b] | joystick[16*p+b];
      for (int b = BUTTONS; b < 15; b++)
        unused_joy = unused_joy ^ joystick[16*p+b];
      req[p] = key_coin[p] | joystick[16*p+15];
    end
  end

  // new press wins, else keep the held direction, else fall back to the lowest pressed one
  always_comb begin
    logic [3:0] d, rise, cand;
    d        = '0;
    rise     = '0;
    cand     = '0;
    filt     = pre;
    dir_next = last_dir;
    if (FOURWAY == 1) begin
      for (int p = 0; p < PLAYERS; p++) begin
        d    = pre[p*BUTTONS +: 4];
        rise = d & ~pre_q[p];
        cand = (rise != 4'd0) ? lowest(rise) : last_dir[p];
        if ((cand & d) == 4'd0) cand = lowest(d);
        dir_next[p]            = cand;
        filt[p*BUTTONS +: 4]   = cand;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_out  <= '0;
      coin     <= '0;
      req_q    <= '0;
      pre_q    <= '0;
      last_dir <= '0;
      cnt      <= '0;
    end else begin
      btn_out  <= filt;
      req_q    <= req;
      last_dir <= dir_next;
      for (int p = 0; p < PLAYERS; p++) begin
        pre_q[p] <= pre[p*BUTTONS +: 4];
        coin[p]  <= (cnt[p] != '0);
        if (cnt[p] != '0)             cnt[p] <= cnt[p] - CW'(1);
        else if (req[p] && !req_q[p]) cnt[p] <= PULSE;
      end
    end
  end
endmodule

// File: tb/tb_arcade_input_merge.sv
// tb/tb_arcade_input_merge.sv - self-checking bench for arcade_input_merge
module tb_arcade_input_merge;
  localparam int P = 2;
  localparam int B = 8;
  localparam int D = 16;
  localparam int N = 5;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] joystick;
  logic [15:0] btn0, btn1;
  logic [1:0]  coin0, coin1;
  logic        busy0, busy1, ovf0, ovf1;

  int tests = 0;
  int fails = 0;

  arcade_input_merge_if #(.MAP_DEPTH(D)) bus ();

  arcade_input_merge #(.PLAYERS(P), .BUTTONS(B), .MAP_DEPTH(D), .COIN_PULSE(N), .FOURWAY(0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus), .joystick(joystick),
    .btn_out(btn0), .coin(coin0), .busy(busy0), .overflow(ovf0));

  arcade_input_merge #(.PLAYERS(P), .BUTTONS(B), .MAP_DEPTH(D), .COIN_PULSE(N), .FOURWAY(1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus), .joystick(joystick),
    .btn_out(btn1), .coin(coin1), .busy(busy1), .overflow(ovf1));

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] joy;
    logic [7:0] fw;
  } fw_vec_t;

  fw_vec_t     fw_tab [12];
  logic [31:0] cmask0, cmask1, cmask_p0;
  logic        busy_all;
  int          dir [2];
  logic [3:0]  prevp [2];
  logic        prevreq [2];
  int          acc [2];
  logic [31:0] cur;
  logic [15:0] e1;
  logic [1:0]  ec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic map_write(input int a, input logic v, input logic [8:0] code, input logic [7:0] tgt);
    bus.map_wr   = 1'b1;
    bus.map_addr = 4'(a);
    bus.map_data = {v, code, tgt};
    step();
    bus.map_wr   = 1'b0;
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy0 || busy1) && n < 100) begin
      step();
      n++;
    end
    check(name, {30'd0, busy0, busy1}, 32'd0);
  endtask

  function automatic int low_idx(input logic [3:0] v);
    low_idx = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) low_idx = i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    fw_tab[0]  = '{8'h00, 8'h00};
    fw_tab[1]  = '{8'h01, 8'h01};
    fw_tab[2]  = '{8'h09, 8'h08};
    fw_tab[3]  = '{8'h09, 8'h08};
    fw_tab[4]  = '{8'h01, 8'h01};
    fw_tab[5]  = '{8'h00, 8'h00};
    fw_tab[6]  = '{8'h06, 8'h02};
    fw_tab[7]  = '{8'h26, 8'h22};
    fw_tab[8]  = '{8'h04, 8'h04};
    fw_tab[9]  = '{8'h0F, 8'h01};
    fw_tab[10] = '{8'h0E, 8'h02};
    fw_tab[11] = '{8'h00, 8'h00};

    bus.ps2_key  = 11'h400;
    bus.map_wr   = 1'b0;
    bus.map_addr = '0;
    bus.map_data = '0;
    joystick     = '0;
    reset_n      = 1'b0;
    stepn(2);
    check("reset_btn", {btn0, btn1}, 32'd0);
    check("reset_flags", {24'd0, coin0, coin1, busy0, busy1, ovf0, ovf1}, 32'd0);
    reset_n = 1'b1;
    stepn(3);
    check("no_event_on_toggle_load", {30'd0, busy0, busy1}, 32'd0);

    // single press: entry 0 scanned in cycle 2, btn_out at cycle 4, idle at cycle 19
    map_write(0, 1'b1, 9'h075, 8'd3);
    map_write(1, 1'b1, 9'h06B, 8'd2);
    key(1'b1, 9'h075);
    step();
    check("press_busy_c1", {30'd0, busy0, busy1}, 32'd0);
    step();
    check("press_busy_c2", {30'd0, busy0, busy1}, 32'd3);
    step();
    check("press_btn_c3", {btn0, btn1}, 32'd0);
    step();
    check("press_btn_c4", {btn0, btn1}, {16'h0008, 16'h0008});
    stepn(14);
    check("press_busy_c18", {30'd0, busy0, busy1}, 32'd3);
    step();
    check("press_busy_c19", {30'd0, busy0, busy1}, 32'd0);
    key(1'b0, 9'h075);
    stepn(3);
    check("release_btn_c3", {btn0, btn1}, {16'h0008, 16'h0008});
    step();
    check("release_btn_c4", {btn0, btn1}, 32'd0);
    wait_idle("release_idle");

    // three consecutive toggles: one scanned, one pending, one dropped
    key(1'b1, 9'h075);
    step();
    key(1'b0, 9'h075);
    step();
    check("ovf_c2", {30'd0, ovf0, ovf1}, 32'd0);
    key(1'b1, 9'h06B);
    busy_all = 1'b1;
    for (int c = 3; c <= 36; c++) begin
      step();
      if (c <= 35) busy_all = busy_all & busy0 & busy1;
      case (c)
        3:  check("ovf_c3", {30'd0, ovf0, ovf1}, 32'd3);
        4:  check("ovf_btn_c4", {btn0, btn1}, {16'h0008, 16'h0008});
        20: check("ovf_btn_c20", {btn0, btn1}, {16'h0008, 16'h0008});
        21: check("ovf_btn_c21", {btn0, btn1}, 32'd0);
        36: check("ovf_busy_c36", {30'd0, busy0, busy1}, 32'd0);
        default: ;
      endcase
    end
    check("ovf_busy_continuous", {31'd0, busy_all}, 32'd1);
    check("ovf_sticky", {30'd0, ovf0, ovf1}, 32'd3);
    check("ovf_dropped_btn", {btn0, btn1}, 32'd0);

    // writes during a scan: unscanned entry 15 is seen, already scanned entry 0 is not
    key(1'b1, 9'h033);
    stepn(3);
    map_write(15, 1'b1, 9'h033, 8'd4);
    map_write(0, 1'b1, 9'h033, 8'd5);
    stepn(13);
    check("late_wr_c18", {btn0, btn1}, 32'd0);
    step();
    check("late_wr_c19", {btn0, btn1}, {16'h0010, 16'h0010});
    wait_idle("late_wr_idle");
    key(1'b0, 9'h033);
    stepn(2);
    wait_idle("late_rel_idle");
    step();
    check("late_rel_btn", {btn0, btn1}, 32'd0);

    // multiple matches: button 0, button 9, player 1 coin, and an ignored target
    map_write(2, 1'b1, 9'h01C, 8'd0);
    map_write(9, 1'b1, 9'h01C, 8'd9);
    map_write(3, 1'b1, 9'h01C, 8'd200);
    map_write(4, 1'b1, 9'h01C, 8'd17);
    key(1'b1, 9'h01C);
    cmask0 = '0; cmask1 = '0; cmask_p0 = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      cmask0[c]   = coin0[1];
      cmask1[c]   = coin1[1];
      cmask_p0[c] = coin0[0] | coin1[0];
      case (c)
        5:  check("multi_c5", {btn0, btn1}, 32'd0);
        6:  check("multi_c6", {btn0, btn1}, {16'h0001, 16'h0001});
        12: check("multi_c12", {btn0, btn1}, {16'h0001, 16'h0001});
        13: check("multi_c13", {btn0, btn1}, {16'h0201, 16'h0201});
        20: check("multi_c20", {btn0, btn1}, {16'h0201, 16'h0201});
        default: ;
      endcase
    end
    check("multi_coin1_fw0", cmask0, 32'h0000_3E00);
    check("multi_coin1_fw1", cmask1, 32'h0000_3E00);
    check("multi_coin0_quiet", cmask_p0, 32'd0);
    key(1'b0, 9'h01C);
    stepn(2);
    wait_idle("multi_rel_idle");
    step();
    check("multi_rel_btn", {btn0, btn1}, 32'd0);

    // joystick coin: edges at 0, 3 (ignored), 8
    stepn(8);
    cmask0 = '0; cmask1 = '0;
    for (int i = 0; i < 18; i++) begin
      joystick = '0;
      joystick[15] = (i == 0 || i == 3 || i == 8);
      step();
      cmask0[i+1] = coin0[0];
      cmask1[i+1] = coin1[0];
    end
    joystick = '0;
    check("coin_joy_fw0", cmask0, 32'h0000_7C7C);
    check("coin_joy_fw1", cmask1, 32'h0000_7C7C);

    // 4-way filter vectors on player 0
    for (int v = 0; v < 12; v++) begin
      joystick = {24'd0, fw_tab[v].joy};
      step();
      check($sformatf("fourway_%0d", v), {btn0, btn1}, {8'd0, fw_tab[v].joy, 8'd0, fw_tab[v].fw});
    end

    // random joystick traffic against the rule-level model
    stepn(10);
    for (int p = 0; p < P; p++) begin
      dir[p] = -1; prevp[p] = '0; prevreq[p] = 1'b0; acc[p] = -100;
    end
    for (int k = 0; k < 400; k++) begin
      cur = $urandom();
      joystick = cur;
      for (int p = 0; p < P; p++) begin
        logic [3:0] pr, rise;
        pr   = cur[16*p +: 4];
        rise = pr & ~prevp[p];
        if (rise != 4'd0) dir[p] = low_idx(rise);
        if (dir[p] < 0 || !pr[dir[p]]) dir[p] = low_idx(pr);
        e1[8*p +: 8] = {cur[16*p+4 +: 4], (dir[p] >= 0) ? 4'(1 << dir[p]) : 4'd0};
        prevp[p] = pr;
        if (cur[16*p+15] && !prevreq[p] && !(k >= acc[p] + 1 && k <= acc[p] + N)) acc[p] = k;
        prevreq[p] = cur[16*p+15];
        ec[p] = (k + 1 >= acc[p] + 2) && (k + 1 <= acc[p] + N + 1);
      end
      step();
      check("rand_btn", {btn0, btn1}, {cur[23:16], cur[7:0], e1});
      check("rand_coin", {28'd0, coin0, coin1}, {28'd0, ec, ec});
    end
    joystick = '0;
    stepn(10);

    // reset in the middle of a scan with buttons held
    joystick = 32'h0000_0002;
    key(1'b1, 9'h01C);
    step();
    check("hold_joy_c1", {btn0, btn1}, {16'h0002, 16'h0002});
    stepn(2);
    wait_idle("hold_idle");
    check("hold_btn", {btn0, btn1}, {16'h0203, 16'h0201});
    key(1'b1, 9'h055);
    stepn(5);
    check("midscan_busy", {30'd0, busy0, busy1}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("async_reset_btn", {btn0, btn1}, 32'd0);
    check("async_reset_flags", {24'd0, coin0, coin1, busy0, busy1, ovf0, ovf1}, 32'd0);
    joystick = '0;
    stepn(2);
    reset_n = 1'b1;
    step();
    key(1'b1, 9'h01C);
    stepn(2);
    check("post_reset_scan", {30'd0, busy0, busy1}, 32'd3);
    wait_idle("post_reset_idle");
    step();
    check("post_reset_btn", {btn0, btn1}, 32'd0);
    check("post_reset_flags", {24'd0, coin0, coin1, busy0, busy1, ovf0, ovf1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
